// File: rtl/ser_to_par_align.sv
// ser_to_par_align
//   Serial-to-parallel receiver with COM-based symbol alignment. Bits arrive
//   MSB first, one per clock when serial_valid_i is high. The receiver hunts
//   for a COM symbol on every bit, confirms the boundary with LOCK_COUNT
//   consecutive aligned COMs, then emits data symbols and strips COM/IDLE.
//   Lock is dropped when MAX_GAP boundary words pass without a COM.
// Ports
//   clk_i           clock, rising edge
//   reset_i         synchronous, active-high
//   serial_i        serial data bit, symbol MSB first
//   serial_valid_i  serial_i valid this cycle; low freezes the receiver
//   data_o          last received data symbol (held between strobes)
//   valid_o         one-cycle strobe: data_o carries a new symbol
//   locked_o        receiver is aligned
module ser_to_par_align #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COM        = 8'hBC,
   parameter logic [WIDTH-1:0] IDLE       = 8'h7C,
   parameter int               LOCK_COUNT = 4,
   parameter int               MAX_GAP    = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             serial_i,
   input  logic             serial_valid_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             locked_o
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam int GW = $clog2(MAX_GAP + 1);

   typedef enum logic [1:0] {S_SEARCH, S_ALIGN, S_LOCKED} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d, sr_next;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]    com_cnt_q, com_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             boundary;

   assign sr_next  = {sr_q[WIDTH-2:0], serial_i};
   assign boundary = (bit_cnt_q == BW'(WIDTH - 1));

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      com_cnt_d = com_cnt_q;
      gap_cnt_d = gap_cnt_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      if (serial_valid_i) begin
         sr_d      = sr_next;
         bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
         case (state_q)
            S_SEARCH: begin
               // Bit-by-bit hunt; a match defines the boundary at this bit.
               bit_cnt_d = '0;
               if (sr_next == COM) begin
                  com_cnt_d = CW'(1);
                  gap_cnt_d = '0;
                  state_d   = (LOCK_COUNT == 1) ? S_LOCKED : S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (boundary) begin
                  if (sr_next == COM) begin
                     com_cnt_d = com_cnt_q + 1'b1;
                     if (com_cnt_q == CW'(LOCK_COUNT - 1)) begin
                        state_d   = S_LOCKED;
                        gap_cnt_d = '0;
                     end
                  end else begin
                     // Misaligned: restart the hunt from the next bit only.
                     state_d   = S_SEARCH;
                     com_cnt_d = '0;
                  end
               end
            end
            S_LOCKED: begin
               if (boundary) begin
                  if (sr_next == COM) begin
                     gap_cnt_d = '0;
                  end else if (gap_cnt_q == GW'(MAX_GAP - 1)) begin
                     // Too long without COM: drop this word and lose lock.
                     state_d   = S_SEARCH;
                     com_cnt_d = '0;
                     gap_cnt_d = '0;
                  end else begin
                     gap_cnt_d = gap_cnt_q + 1'b1;
                     if (sr_next != IDLE) begin
                        data_d  = sr_next;
                        valid_d = 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_d = S_SEARCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_SEARCH;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         com_cnt_q <= '0;
         gap_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

   assign data_o   = data_q;
   assign valid_o  = valid_q;
   assign locked_o = (state_q == S_LOCKED);

endmodule

// File: tb/tb_ser_to_par_align.sv
// tb_ser_to_par_align
//   Directed scenarios plus randomized symbol streams, checked every cycle
//   against a bit-stream reference model of the alignment rules.
module tb_ser_to_par_align;

   localparam int          LC   = 4;
   localparam int          MG   = 16;
   localparam logic [7:0]  COMS = 8'hBC;
   localparam logic [7:0]  IDLS = 8'h7C;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       serial_i = 1'b0;
   logic       serial_valid_i = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic       locked_o;

   ser_to_par_align #(.WIDTH(8), .COM(COMS), .IDLE(IDLS), .LOCK_COUNT(LC), .MAX_GAP(MG)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .serial_i(serial_i), .serial_valid_i(serial_valid_i),
      .data_o(data_o), .valid_o(valid_o), .locked_o(locked_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;
   int cyc_n = 0;
   int got_d[$];
   int got_t[$];

   // Reference model: history of the last 8 valid bits, phase, counts.
   int   m_win, m_phase, m_since, m_coms, m_gap;   // phase: 0 hunt, 1 confirm, 2 aligned
   logic [7:0] e_data;
   logic e_valid, e_locked;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   task automatic model(input logic r, input logic v, input logic b);
      if (r) begin
         m_win = 0; m_phase = 0; m_since = 0; m_coms = 0; m_gap = 0;
         e_data = 0; e_valid = 0; e_locked = 0;
         return;
      end
      e_valid = 0;
      if (!v) return;
      m_win = ((m_win * 2) + int'(b)) % 256;
      if (m_phase == 0) begin
         if (m_win == int'(COMS)) begin
            m_since = 0; m_coms = 1; m_gap = 0;
            m_phase = (LC == 1) ? 2 : 1;
         end
      end else begin
         m_since++;
         if (m_since == 8) begin
            m_since = 0;
            if (m_phase == 1) begin
               if (m_win == int'(COMS)) begin
                  m_coms++;
                  if (m_coms == LC) begin m_phase = 2; m_gap = 0; end
               end else begin
                  m_phase = 0; m_coms = 0;
               end
            end else begin
               if (m_win == int'(COMS)) m_gap = 0;
               else if (m_gap == MG - 1) begin m_phase = 0; m_coms = 0; m_gap = 0; end
               else begin
                  m_gap++;
                  if (m_win != int'(IDLS)) begin e_data = 8'(m_win); e_valid = 1; end
               end
            end
         end
      end
      e_locked = (m_phase == 2);
   endtask

   // One clock: drive, let the edge happen, update model, compare 1ns later.
   task automatic cyc(input logic r, input logic v, input logic b);
      reset_i = r; serial_valid_i = v; serial_i = b;
      @(posedge clk_i);
      model(r, v, b);
      #1;
      cyc_n++;
      check("valid", 32'(valid_o), 32'(e_valid));
      check("data", 32'(data_o), 32'(e_data));
      check("locked", 32'(locked_o), 32'(e_locked));
      if (valid_o === 1'b1) begin got_d.push_back(int'(data_o)); got_t.push_back(cyc_n); end
   endtask

   task automatic sym(input logic [7:0] s);
      for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, s[i]);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      got_d.delete(); got_t.delete();
   endtask

   task automatic lock4();
      for (int i = 0; i < 4; i++) sym(COMS);
   endtask

   int t0;
   logic [7:0] w;

   initial begin
      // 1: reset with random bits
      do_reset(2);
      check("s1_valid", 32'(valid_o), 0);
      check("s1_data", 32'(data_o), 0);
      check("s1_locked", 32'(locked_o), 0);

      // 2: FF, 4x COM, 55
      do_reset(1);
      sym(8'hFF);
      for (int i = 0; i < 3; i++) sym(COMS);
      for (int i = 7; i >= 1; i--) cyc(1'b0, 1'b1, COMS[i]);
      check("s2_prelock", 32'(locked_o), 0);
      cyc(1'b0, 1'b1, COMS[0]);
      check("s2_lock", 32'(locked_o), 1);
      t0 = cyc_n;
      sym(8'h55);
      check("s2_n", 32'(got_d.size()), 1);
      check("s2_d", 32'(got_d[0]), 32'h55);
      check("s2_t", 32'(got_t[0] - t0), 8);

      // 3: junk bits, lock, A5 7C 3C
      do_reset(1);
      cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1);
      lock4();
      sym(8'hA5); sym(IDLS); sym(8'h3C);
      check("s3_n", 32'(got_d.size()), 2);
      check("s3_d0", 32'(got_d[0]), 32'hA5);
      check("s3_d1", 32'(got_d[1]), 32'h3C);
      check("s3_gap", 32'(got_t[1] - got_t[0]), 16);

      // 4: broken COM run then a full one
      do_reset(1);
      sym(COMS); sym(COMS); sym(8'h00);
      for (int i = 0; i < 3; i++) sym(COMS);
      check("s4_nolock", 32'(locked_o), 0);
      sym(COMS);
      check("s4_lock", 32'(locked_o), 1);
      sym(8'h11);
      check("s4_n", 32'(got_d.size()), 1);
      check("s4_d", 32'(got_d[0]), 32'h11);

      // 5: stall in the middle of a symbol
      do_reset(1);
      lock4();
      t0 = cyc_n;
      w = 8'h5A;
      for (int i = 7; i >= 5; i--) cyc(1'b0, 1'b1, w[i]);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 4; i >= 0; i--) cyc(1'b0, 1'b1, w[i]);
      check("s5_n", 32'(got_d.size()), 1);
      check("s5_d", 32'(got_d[0]), 32'h5A);
      check("s5_t", 32'(got_t[0] - t0), 13);

      // 6: gap timeout, then reset mid-word
      do_reset(1);
      lock4();
      for (int i = 1; i <= 16; i++) sym(8'(i));
      check("s6_n", 32'(got_d.size()), 15);
      for (int i = 0; i < 15; i++) check("s6_d", 32'(got_d[i]), 32'(i + 1));
      check("s6_unlock", 32'(locked_o), 0);
      got_d.delete();
      lock4();
      w = 8'h99;
      for (int i = 7; i >= 4; i--) cyc(1'b0, 1'b1, w[i]);
      cyc(1'b1, 1'b1, 1'b0);
      check("s6_rst_locked", 32'(locked_o), 0);
      check("s6_rst_data", 32'(data_o), 0);
      for (int i = 3; i >= 0; i--) cyc(1'b0, 1'b1, w[i]);
      check("s6_rst_n", 32'(got_d.size()), 0);

      // Randomized symbol streams with stalls, misalignment and resets
      do_reset(1);
      for (int s = 0; s < 400; s++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r == 99) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if (r < 6) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
         end else begin
            if (r < 45) w = COMS;
            else if (r < 55) w = IDLS;
            else w = 8'($urandom_range(0, 255));
            for (int i = 7; i >= 0; i--) begin
               if ($urandom_range(0, 9) == 0) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
               cyc(1'b0, 1'b1, w[i]);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
